// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot FSM state encoding and datapath widths,
// common to the transmitter and the receiver.
package uart_pkg;

  localparam int BR_WIDTH   = 15;
  localparam int DATA_WIDTH = 8;

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } uart_state_e;

endpackage

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter with a one-deep holding register, runtime bit
// divisor latched per frame, optional parity and one or two stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BR_WIDTH-1:0]   BR_Clocks,
  input  logic [DATA_WIDTH-1:0] Tx_Data,
  input  logic                  Tx_Start,
  output logic                  Tx_Ready,
  output logic                  Tx_Serial,
  output logic                  Tx_Busy,
  output logic                  Tx_Done
);

  if (!(STOP_BITS == 1 || STOP_BITS == 2)) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam logic [BR_WIDTH-1:0] CNT_ONE = 1;

  uart_state_e           r_state;
  logic [BR_WIDTH-1:0]   r_br;
  logic [BR_WIDTH-1:0]   r_cnt;
  logic [2:0]            r_bit_idx;
  logic                  r_stop_idx;
  logic                  r_ready;
  logic                  r_serial;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] r_shift;

  logic w_cnt_last;
  logic w_stop_last;
  logic w_frame_end;
  logic w_accept;
  logic w_load;
  logic w_parity;

  assign w_cnt_last  = (r_cnt == r_br);
  assign w_stop_last = (STOP_BITS == 1) ? 1'b1 : r_stop_idx;
  assign w_frame_end = (r_state == STOP) && w_cnt_last && w_stop_last;
  assign w_accept    = Tx_Start && r_ready;
  // r_ready low means the holding register is full
  assign w_load      = !r_ready && ((r_state == IDLE) || w_frame_end);
  assign w_parity    = (^r_shift) ^ (PARITY_ODD != 0);

  always_ff @(posedge clk) begin
    if (w_accept) r_hold  <= Tx_Data;
    if (w_load)   r_shift <= r_hold;
  end

  // Tx_Done is registered, so it is raised one edge early, on entry to
  // the last cycle of the last stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_br       <= '0;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_ready    <= 1'b1;
      r_serial   <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) r_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          r_serial <= 1'b1;
          if (w_load) begin
            r_ready  <= 1'b1;
            r_br     <= BR_Clocks;
            r_cnt    <= '0;
            r_state  <= START;
            r_serial <= 1'b0;
          end
        end
        START: begin
          if (w_cnt_last) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= DATA;
            r_serial  <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (w_cnt_last) begin
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              if (PARITY_EN != 0) begin
                r_state  <= PARITY;
                r_serial <= w_parity;
              end else begin
                r_state    <= STOP;
                r_serial   <= 1'b1;
                r_stop_idx <= 1'b0;
                r_done     <= (r_br == '0) && (STOP_BITS == 1);
              end
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_serial  <= r_shift[r_bit_idx + 3'd1];
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        PARITY: begin
          if (w_cnt_last) begin
            r_cnt      <= '0;
            r_state    <= STOP;
            r_serial   <= 1'b1;
            r_stop_idx <= 1'b0;
            r_done     <= (r_br == '0) && (STOP_BITS == 1);
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        STOP: begin
          if (w_cnt_last) begin
            r_cnt <= '0;
            if (w_stop_last) begin
              if (w_load) begin
                r_ready  <= 1'b1;
                r_br     <= BR_Clocks;
                r_state  <= START;
                r_serial <= 1'b0;
              end else begin
                r_state  <= IDLE;
                r_serial <= 1'b1;
              end
            end else begin
              r_stop_idx <= 1'b1;
              r_done     <= (r_br == '0);
            end
          end else begin
            r_cnt  <= r_cnt + CNT_ONE;
            r_done <= w_stop_last && ((r_cnt + CNT_ONE) == r_br);
          end
        end
        default: begin
          r_state  <= IDLE;
          r_serial <= 1'b1;
        end
      endcase
    end
  end

  assign Tx_Ready  = r_ready;
  assign Tx_Serial = r_serial;
  assign Tx_Busy   = (r_state != IDLE);
  assign Tx_Done   = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: an 8N1 instance and a parity-odd/2-stop instance share
// stimulus; a frame-level model predicts every output on every cycle.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] br = 15'd15;
  logic [7:0]  data = 8'h00;
  logic        start = 1'b0;

  logic rdy0, ser0, busy0, done0;
  logic rdy1, ser1, busy1, done1;
  logic [3:0] o [2];
  assign o[0] = {ser0, busy0, rdy0, done0};
  assign o[1] = {ser1, busy1, rdy1, done1};

  always #5 clk = ~clk;

  uart_tx u_dut0 (
    .clk(clk), .rst_n(rst_n), .BR_Clocks(br), .Tx_Data(data), .Tx_Start(start),
    .Tx_Ready(rdy0), .Tx_Serial(ser0), .Tx_Busy(busy0), .Tx_Done(done0)
  );

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .BR_Clocks(br), .Tx_Data(data), .Tx_Start(start),
    .Tx_Ready(rdy1), .Tx_Serial(ser1), .Tx_Busy(busy1), .Tx_Done(done1)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame is a list of line levels, each held for one
  // bit period; the output is the level at position/period.
  int          P_EN   [2] = '{0, 1};
  int          P_ODD  [2] = '{0, 1};
  int          P_STOP [2] = '{1, 2};
  bit          m_full [2];
  logic [7:0]  m_hold [2];
  bit          m_in   [2];
  int          m_pos  [2];
  int          m_per  [2];
  int          m_nb   [2];
  logic [11:0] m_bits [2];

  function automatic void m_step(int m);
    bit          fend;
    bit          was_full;
    logic [11:0] b;
    int          n;
    was_full = m_full[m];
    fend = m_in[m] && (m_pos[m] == m_nb[m] * m_per[m] - 1);
    if (m_full[m] && (!m_in[m] || fend)) begin
      b = '1;
      b[0] = 1'b0;
      b[8:1] = m_hold[m];
      n = 9;
      if (P_EN[m] != 0) begin
        b[9] = (^m_hold[m]) ^ (P_ODD[m] != 0);
        n = 10;
      end
      m_bits[m] = b;
      m_nb[m]   = n + P_STOP[m];
      m_per[m]  = int'(br) + 1;
      m_pos[m]  = 0;
      m_in[m]   = 1'b1;
      m_full[m] = 1'b0;
    end else if (fend) begin
      m_in[m] = 1'b0;
    end else if (m_in[m]) begin
      m_pos[m]++;
    end
    if (start && !was_full) begin
      m_full[m] = 1'b1;
      m_hold[m] = data;
    end
  endfunction

  function automatic logic [3:0] m_out(int m);
    logic s;
    logic d;
    s = m_in[m] ? m_bits[m][m_pos[m] / m_per[m]] : 1'b1;
    d = m_in[m] && (m_pos[m] == m_nb[m] * m_per[m] - 1);
    return {s, m_in[m], !m_full[m], d};
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int m = 0; m < 2; m++) begin
          m_full[m] = 1'b0;
          m_in[m]   = 1'b0;
          m_pos[m]  = 0;
          m_per[m]  = 1;
          m_nb[m]   = 10;
        end
      end else begin
        for (int m = 0; m < 2; m++) m_step(m);
      end
    end
  end

  int bcount0 = 0;
  int dcount0 = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cycle_m0 {ser,busy,rdy,done}", {28'd0, o[0]}, {28'd0, m_out(0)});
      chk("cycle_m1 {ser,busy,rdy,done}", {28'd0, o[1]}, {28'd0, m_out(1)});
      if (busy0) bcount0++;
      if (done0) dcount0++;
    end
  end

  task automatic send(input logic [7:0] d);
    @(posedge clk);
    #1;
    data  = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Call right after send(): measures latency to busy, busy length, done
  // position and mid-bit line samples of instance m.
  task automatic measure(input int m, input int per, output int lat, output int blen,
                         output int dat, output int ndone, output logic [11:0] bits);
    lat = 0; blen = 0; dat = 0; ndone = 0; bits = '0;
    do begin
      @(negedge clk);
      lat++;
    end while (!o[m][2] && lat < 20);
    while (o[m][2] && blen < 5000) begin
      blen++;
      if ((blen - 1) % per == per / 2) bits[(blen - 1) / per] = o[m][3];
      if (o[m][0]) begin
        dat = blen;
        ndone++;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(rdy0 && rdy1 && !busy0 && !busy1) && k < 10000) begin
      @(posedge clk);
      k++;
    end
    chk("wait_idle_bound", k < 10000, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, blen, dat, nd, b0, d0, k;
    logic [11:0] bits;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_m0", {28'd0, o[0]}, 32'hA);
    chk("reset_m1", {28'd0, o[1]}, 32'hA);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // single byte, 8N1
    br = 15'd15;
    send(8'hA5);
    measure(0, 16, lat, blen, dat, nd, bits);
    chk("a5_latency", lat, 2);
    chk("a5_busy_len", blen, 160);
    chk("a5_done_cycle", dat, 160);
    chk("a5_done_count", nd, 1);
    chk("a5_bits", {22'd0, bits[9:0]}, {22'd0, 10'b1101001010});
    wait_idle();

    // parity odd, two stop bits
    send(8'h07);
    measure(1, 16, lat, blen, dat, nd, bits);
    chk("p07_latency", lat, 2);
    chk("p07_busy_len", blen, 192);
    chk("p07_done_cycle", dat, 192);
    chk("p07_bits", {20'd0, bits}, {20'd0, 12'b110000001110});
    wait_idle();

    // back-to-back with a third request ignored
    d0 = dcount0;
    send(8'h00);
    repeat (30) @(posedge clk);
    #1;
    send(8'hFF);
    repeat (3) @(posedge clk);
    #1;
    send(8'h3C);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done0 && k < 400);
    chk("b2b_first_done", done0, 1);
    @(negedge clk);
    chk("b2b_no_gap {ser,busy}", {30'd0, ser0, busy0}, 32'd1);
    wait_idle();
    chk("b2b_frame_count", dcount0 - d0, 2);

    // divisor change mid-frame
    b0 = bcount0;
    send(8'h5A);
    repeat (20) @(posedge clk);
    #1;
    br = 15'd7;
    send(8'hC3);
    wait_idle();
    chk("div_busy_total", bcount0 - b0, 240);
    br = 15'd0;
    send(8'h81);
    measure(0, 1, lat, blen, dat, nd, bits);
    chk("br0_busy_len", blen, 10);
    chk("br0_bits", {22'd0, bits[9:0]}, {22'd0, 10'b1100000010});
    wait_idle();

    // randomized traffic
    br = 15'd3;
    repeat (3000) begin
      @(posedge clk);
      #1;
      start = ($urandom_range(0, 5) == 0);
      data  = 8'($urandom);
      if ($urandom_range(0, 199) == 0) br = 15'($urandom_range(0, 9));
    end
    start = 1'b0;
    wait_idle();

    // reset during data bit 3 with a byte held
    br = 15'd15;
    send(8'h5A);
    send(8'h11);
    repeat (66) @(posedge clk);
    chk("pre_reset_busy", busy0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_m0", {28'd0, o[0]}, 32'hA);
    chk("rst_mid_m1", {28'd0, o[1]}, 32'hA);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    b0 = bcount0;
    d0 = dcount0;
    repeat (200) @(posedge clk);
    #1;
    chk("post_reset_busy_cycles", bcount0 - b0, 0);
    chk("post_reset_done_count", dcount0 - d0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Byte-wide UART transmitter, 8N1 framing by default: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Bit timing is set by the runtime BR_Clocks divisor, the same divisor the UART_Rx receiver uses, so a Tx/Rx pair on one BR_Clocks value interoperates.
- A one-deep holding register lets the host queue the next byte while the current frame shifts out, giving back-to-back frames with no idle gap.

Parameters:
- PARITY_EN, 0: 1 inserts a parity bit after data bit 7.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2, any other value is an elaboration error.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- BR_Clocks  in  15  bit-period divisor; one bit lasts BR_Clocks+1 clk cycles.
- Tx_Data  in  8  byte to send; sampled when Tx_Start && Tx_Ready.
- Tx_Start  in  1  single-cycle request strobe.
- Tx_Ready  out  1  high when the holding register is empty and a request will be accepted.
- Tx_Serial  out  1  serial line, idles high.
- Tx_Busy  out  1  high while any frame bit (start through last stop) is on the line.
- Tx_Done  out  1  one-cycle pulse in the final cycle of the last stop bit.

Behaviour:
- Reset (async assert, sync release):
  - Tx_Serial=1, Tx_Ready=1, Tx_Busy=0, Tx_Done=0.
  - State=IDLE; holding register empty; counters zero.
  - Reset mid-frame forces Tx_Serial high immediately and discards both the in-flight byte and any held byte.
- Accept:
  - Tx_Start && Tx_Ready captures Tx_Data into the holding register.
  - Tx_Ready drops on the next cycle.
  - Tx_Start while Tx_Ready=0 is ignored; there is no error flag.
- States are one-hot: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Tx_Serial=1.
  - If the holding register is full: move the byte to the shift register, mark the holding register empty (Tx_Ready=1 next cycle), latch BR_Clocks into an internal copy, clear clk_count, and go to START.
  - Latency: a Tx_Start accepted in cycle N gives the start bit on Tx_Serial in cycle N+2.
- START:
  - Tx_Serial=0 for latched_BR+1 cycles (clk_count runs 0..latched_BR), then go to DATA with bitIndex=0.
- DATA:
  - Tx_Serial=shift[bitIndex] for latched_BR+1 cycles per bit.
  - After bitIndex=7, go to PARITY if PARITY_EN, else to STOP.
- PARITY:
  - Tx_Serial = XOR of the 8 data bits, inverted if PARITY_ODD; held for one bit period.
- STOP:
  - Tx_Serial=1 for STOP_BITS bit periods.
  - In the final cycle: pulse Tx_Done.
  - If the holding register is full, skip IDLE: reload shift register and BR_Clocks copy, clear clk_count, go directly to START (zero idle cycles between frames). Otherwise go to IDLE.
- Tx_Busy = (state != IDLE).
- Divisor:
  - BR_Clocks is latched only at frame start; changes mid-frame take effect on the next frame.
  - BR_Clocks=0 is legal: one clk per bit.
  - clk_count is 15 bits and is compared with ==, so it cannot wrap.
- Tx_Serial is driven from a flop; no combinational path from any input.
- Simultaneous events:
  - Tx_Start in the same cycle the holding register empties is not accepted, because Tx_Ready is still 0 that cycle.
  - Accept in the final STOP cycle is possible only if Tx_Ready was already 1; that byte is then queued for the following frame.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings IDLE/START/DATA/PARITY/STOP (shared with the receiver);
  - BR_WIDTH=15 and DATA_WIDTH=8.
- No sub-module. A single always_ff FSM plus the holding register; the parity XOR is inline.

Test Plan:
- Single byte: BR_Clocks=15, send 0xA5, 8N1 → Tx_Serial reads 0, 1,0,1,0,0,1,0,1, 1, each level held 16 clk; Tx_Done pulses once in cycle 160 after start; Tx_Busy high for exactly 160 cycles.
- Back-to-back: queue 0x00 then 0xFF, the second while the first is in DATA → the second start bit follows the stop bit of the first with zero idle cycles; a third Tx_Start during that window is ignored (Tx_Ready=0).
- Loopback: uart_tx → UART_Rx, same BR_Clocks=867, bytes 0x00/0x55/0xAA/0xFF/random ×256 → every Rx_Data matches and r_DV pulses once per byte.
- Parity/stop: PARITY_EN=1, PARITY_ODD=1, STOP_BITS=2, byte 0x07 → parity bit 0, then two stop periods of 1; frame length 12 bit periods.
- Divisor change: change BR_Clocks 15→7 mid-frame → the current frame keeps 16-cycle bits and the next frame uses 8-cycle bits; with BR_Clocks=0, each bit lasts 1 cycle.
- Reset mid-DATA: assert rst_n=0 at bitIndex=3 → Tx_Serial=1 asynchronously, Tx_Ready=1, Tx_Busy=0; no Tx_Done; the held byte is discarded and nothing is sent after release.
